// File: rtl/vmul_pkg.sv
// rtl/vmul_pkg.sv - shared types and helpers for the vector-multiply sequencer
package vmul_pkg;

   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [1:0] {
      SEW8  = 2'b00,
      SEW16 = 2'b01,
      SEW32 = 2'b10
   } sew_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_OPND,
      S_MUL,
      S_WAIT,
      S_WB,
      S_DONE
   } state_e;

   function automatic logic [2:0] sew_bytes(sew_e sew);
      case (sew)
         SEW16:   sew_bytes = 3'd2;
         SEW32:   sew_bytes = 3'd4;
         default: sew_bytes = 3'd1;
      endcase
   endfunction

endpackage

// File: rtl/vmul_be_gen.sv
// rtl/vmul_be_gen.sv - write byte-enable and last-word generation (VMUL_MASK_EN adds element masking)
module vmul_be_gen
   import vmul_pkg::*;
#(
   parameter int VLEN  = 512,
   parameter int VL_W  = $clog2(VLEN/8) + 1,
   parameter int IDX_W = VL_W
) (
   input  logic [1:0]                sew,
   input  logic [VL_W-1:0]           vl,
   input  logic [IDX_W-1:0]          idx,
`ifdef VMUL_MASK_EN
   input  logic [VLEN/8-1:0]         vmask,
`endif
   output logic [BYTES_PER_WORD-1:0] be,
   output logic                      last_word
);

   localparam int NB_W   = VL_W + 2;
   localparam int REM_W  = $clog2(BYTES_PER_WORD);

   logic [NB_W-1:0]           nbytes;
   logic [NB_W-1:0]           nwords;
   logic [REM_W-1:0]          rem;
   logic [BYTES_PER_WORD-1:0] tail_be;

   assign nbytes    = NB_W'(vl) * NB_W'(sew_bytes(sew_e'(sew)));
   assign nwords    = (nbytes + NB_W'(BYTES_PER_WORD - 1)) >> REM_W;
   assign rem       = nbytes[REM_W-1:0];
   assign last_word = (NB_W'(idx) == nwords - NB_W'(1));
   assign tail_be   = (BYTES_PER_WORD'(1) << rem) - BYTES_PER_WORD'(1);

`ifdef VMUL_MASK_EN
   localparam int EIDX_W = $clog2(VLEN/8);
   logic [EIDX_W-1:0] epos;
`endif

   always_comb begin
      be = (last_word && rem != '0) ? tail_be : '1;
`ifdef VMUL_MASK_EN
      epos = '0;
      // element index of each byte lane: (idx*4 + byte) / element size
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
         epos = EIDX_W'((NB_W'(idx) * NB_W'(BYTES_PER_WORD) + NB_W'(b)) >> sew);
         if (!vmask[epos]) be[b] = 1'b0;
      end
`endif
   end

endmodule

// File: rtl/vmul_seq_ctrl.sv
// rtl/vmul_seq_ctrl.sv - vector-multiply instruction sequencer over a SEW-packed multiplier lane
// Optional element masking via VMUL_MASK_EN.
module vmul_seq_ctrl
   import vmul_pkg::*;
#(
   parameter int REG_WIDTH = 32,
   parameter int VLEN      = 512,
   parameter int ADDR_W    = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_sew,
   input  logic [$clog2(VLEN/8):0]  cmd_vl,
   input  logic [ADDR_W-1:0]        cmd_vs1,
   input  logic [ADDR_W-1:0]        cmd_vs2,
   input  logic [ADDR_W-1:0]        cmd_vd,
`ifdef VMUL_MASK_EN
   input  logic [VLEN/8-1:0]        cmd_vmask,
`endif
   output logic [ADDR_W-1:0]        rf_rd_addr_a,
   output logic [ADDR_W-1:0]        rf_rd_addr_b,
   input  logic [REG_WIDTH-1:0]     rf_rd_data_a,
   input  logic [REG_WIDTH-1:0]     rf_rd_data_b,
   output logic                     mul_in_valid,
   input  logic                     mul_in_ready,
   output logic [1:0]               mul_sew,
   output logic [REG_WIDTH-1:0]     mul_a,
   output logic [REG_WIDTH-1:0]     mul_b,
   input  logic                     mul_res_valid,
   input  logic [REG_WIDTH-1:0]     mul_res,
   output logic                     rf_wr_en,
   output logic [ADDR_W-1:0]        rf_wr_addr,
   output logic [REG_WIDTH-1:0]     rf_wr_data,
   output logic [REG_WIDTH/8-1:0]   rf_wr_be,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   localparam int VL_W = $clog2(VLEN/8) + 1;
   localparam logic [VL_W-1:0] VLMAX = VL_W'(VLEN/8);

   state_e                 state_q, state_d;
   logic [1:0]             sew_q;
   logic [VL_W-1:0]        vl_q;
   logic [VL_W-1:0]        idx_q;
   logic [ADDR_W-1:0]      vs1_q, vs2_q, vd_q;
   logic                   err_q;
   logic [REG_WIDTH-1:0]   res_q;
   logic [REG_WIDTH/8-1:0] be_raw;
   logic                   last_word;
`ifdef VMUL_MASK_EN
   logic [VLEN/8-1:0]      vmask_q;
`endif

   vmul_be_gen #(
      .VLEN  (VLEN),
      .VL_W  (VL_W),
      .IDX_W (VL_W)
   ) u_be_gen (
      .sew       (sew_q),
      .vl        (vl_q),
      .idx       (idx_q),
`ifdef VMUL_MASK_EN
      .vmask     (vmask_q),
`endif
      .be        (be_raw),
      .last_word (last_word)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         sew_q   <= '0;
         vl_q    <= '0;
         idx_q   <= '0;
         vs1_q   <= '0;
         vs2_q   <= '0;
         vd_q    <= '0;
         err_q   <= 1'b0;
         res_q   <= '0;
         mul_a   <= '0;
         mul_b   <= '0;
`ifdef VMUL_MASK_EN
         vmask_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  sew_q   <= cmd_sew;
                  vl_q    <= (cmd_vl > VLMAX) ? VLMAX : cmd_vl;
                  vs1_q   <= cmd_vs1;
                  vs2_q   <= cmd_vs2;
                  vd_q    <= cmd_vd;
                  err_q   <= (cmd_sew == 2'b11);
                  idx_q   <= '0;
`ifdef VMUL_MASK_EN
                  vmask_q <= cmd_vmask;
`endif
               end
            end
            S_OPND: begin
               mul_a <= rf_rd_data_a;
               mul_b <= rf_rd_data_b;
            end
            S_WAIT: begin
               if (mul_res_valid) res_q <= mul_res;
            end
            S_WB: begin
               if (!last_word) idx_q <= idx_q + VL_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d      = state_q;
      rf_rd_addr_a = '0;
      rf_rd_addr_b = '0;
      mul_in_valid = 1'b0;
      rf_wr_en     = 1'b0;
      rf_wr_addr   = '0;
      rf_wr_data   = '0;
      rf_wr_be     = '0;
      done         = 1'b0;
      err          = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               if (cmd_sew == 2'b11 || cmd_vl == '0) state_d = S_DONE;
               else                                  state_d = S_RD;
            end
         end
         S_RD: begin
            rf_rd_addr_a = vs1_q + ADDR_W'(idx_q);
            rf_rd_addr_b = vs2_q + ADDR_W'(idx_q);
            state_d      = S_OPND;
         end
         S_OPND: state_d = S_MUL;
         S_MUL: begin
            mul_in_valid = 1'b1;
            if (mul_in_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (mul_res_valid) state_d = S_WB;
         end
         S_WB: begin
            // a fully masked word still consumed a multiply but is not written
            rf_wr_en   = (be_raw != '0);
            rf_wr_addr = vd_q + ADDR_W'(idx_q);
            rf_wr_data = res_q;
            rf_wr_be   = be_raw;
            state_d    = last_word ? S_DONE : S_RD;
         end
         S_DONE: begin
            done    = 1'b1;
            err     = err_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign mul_sew   = sew_q;

endmodule

// File: tb/tb_vmul_seq_ctrl.sv
// tb/tb_vmul_seq_ctrl.sv - scoreboard bench for vmul_seq_ctrl (VMUL_MASK_EN enables mask cases)
module tb_vmul_seq_ctrl;

   localparam int REG_WIDTH = 32;
   localparam int VLEN      = 512;
   localparam int ADDR_W    = 8;
   localparam int VL_W      = $clog2(VLEN/8) + 1;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 cmd_valid = 1'b0;
   logic                 cmd_ready;
   logic [1:0]           cmd_sew = '0;
   logic [VL_W-1:0]      cmd_vl = '0;
   logic [ADDR_W-1:0]    cmd_vs1 = '0, cmd_vs2 = '0, cmd_vd = '0;
`ifdef VMUL_MASK_EN
   logic [VLEN/8-1:0]    cmd_vmask = '1;
   logic [VLEN/8-1:0]    next_vmask = '1;
`endif
   logic [ADDR_W-1:0]    rf_rd_addr_a, rf_rd_addr_b;
   logic [REG_WIDTH-1:0] rf_rd_data_a = '0, rf_rd_data_b = '0;
   logic                 mul_in_valid;
   logic                 mul_in_ready = 1'b0;
   logic [1:0]           mul_sew;
   logic [REG_WIDTH-1:0] mul_a, mul_b;
   logic                 mul_res_valid = 1'b0;
   logic [REG_WIDTH-1:0] mul_res = '0;
   logic                 rf_wr_en;
   logic [ADDR_W-1:0]    rf_wr_addr;
   logic [REG_WIDTH-1:0] rf_wr_data;
   logic [3:0]           rf_wr_be;
   logic                 busy, done, err;

   vmul_seq_ctrl #(
      .REG_WIDTH (REG_WIDTH),
      .VLEN      (VLEN),
      .ADDR_W    (ADDR_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_sew       (cmd_sew),
      .cmd_vl        (cmd_vl),
      .cmd_vs1       (cmd_vs1),
      .cmd_vs2       (cmd_vs2),
      .cmd_vd        (cmd_vd),
`ifdef VMUL_MASK_EN
      .cmd_vmask     (cmd_vmask),
`endif
      .rf_rd_addr_a  (rf_rd_addr_a),
      .rf_rd_addr_b  (rf_rd_addr_b),
      .rf_rd_data_a  (rf_rd_data_a),
      .rf_rd_data_b  (rf_rd_data_b),
      .mul_in_valid  (mul_in_valid),
      .mul_in_ready  (mul_in_ready),
      .mul_sew       (mul_sew),
      .mul_a         (mul_a),
      .mul_b         (mul_b),
      .mul_res_valid (mul_res_valid),
      .mul_res       (mul_res),
      .rf_wr_en      (rf_wr_en),
      .rf_wr_addr    (rf_wr_addr),
      .rf_wr_data    (rf_wr_data),
      .rf_wr_be      (rf_wr_be),
      .busy          (busy),
      .done          (done),
      .err           (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
      logic [3:0]  be;
   } wr_t;

   wr_t  exp_wr[$];
   logic exp_done[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   done_cnt = 0;
   int   done_target = 0;
   int   stall_cfg = 0;
   int   mul_lat = 1;
   logic [1:0] cur_sew = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, expv);
      end
   endtask

   function automatic logic [31:0] vrf_a(input logic [7:0] a);
      return {8'hA5, a, 8'h11, a};
   endfunction

   function automatic logic [31:0] vrf_b(input logic [7:0] b);
      return {8'h03, b, 8'h20, b};
   endfunction

   // the stand-in multiplier returns a + b, so a write proves both operand routings
   task automatic push_wr(input logic [7:0] addr, input logic [7:0] ra, input logic [7:0] rb,
                          input logic [3:0] be);
      wr_t w;
      w.addr = addr;
      w.data = vrf_a(ra) + vrf_b(rb);
      w.be   = be;
      exp_wr.push_back(w);
   endtask

   task automatic push_done(input logic e);
      exp_done.push_back(e);
      done_target++;
   endtask

   task automatic issue(input logic [1:0] sew, input logic [VL_W-1:0] vl,
                        input logic [7:0] vs1, input logic [7:0] vs2, input logic [7:0] vd);
      int t = 0;
      @(negedge clk);
      while (!cmd_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!cmd_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL issue_ready_timeout: cmd_ready=%0b after %0d cycles, expected 1", cmd_ready, t);
      end
      cmd_valid = 1'b1;
      cmd_sew   = sew;
      cmd_vl    = vl;
      cmd_vs1   = vs1;
      cmd_vs2   = vs2;
      cmd_vd    = vd;
`ifdef VMUL_MASK_EN
      cmd_vmask = next_vmask;
`endif
      cur_sew   = sew;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int t = 0;
      while (done_cnt < done_target && t < 3000) begin
         @(negedge clk);
         t++;
      end
      n_cmp++;
      if (done_cnt < done_target) begin
         n_fail++;
         $display("FAIL %s_done_timeout: done count %0d, expected %0d", name, done_cnt, done_target);
      end
   endtask

   // monitor: every write and done pulse is matched against the scoreboard
   always @(negedge clk) begin
      if (rf_wr_en) begin
         if (exp_wr.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_write: addr 0x%h be 0x%h, expected no write", rf_wr_addr, rf_wr_be);
         end else begin
            wr_t e;
            e = exp_wr.pop_front();
            check("wr_addr", {24'h0, rf_wr_addr}, {24'h0, e.addr});
            check("wr_data", rf_wr_data, e.data);
            check("wr_be", {28'h0, rf_wr_be}, {28'h0, e.be});
         end
      end
      if (done) begin
         done_cnt++;
         if (exp_done.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: err=%0b, expected no done", err);
         end else begin
            logic e;
            e = exp_done.pop_front();
            check("done_err", {31'h0, err}, {31'h0, e});
         end
      end
   end

   // VRF model: one-cycle registered read
   logic [7:0] ra_l, rb_l;
   always begin
      @(negedge clk);
      ra_l = rf_rd_addr_a;
      rb_l = rf_rd_addr_b;
      @(posedge clk);
      #1;
      rf_rd_data_a = vrf_a(ra_l);
      rf_rd_data_b = vrf_b(rb_l);
   end

   // multiplier model with configurable ready stall and result latency
   logic [31:0] pa, pb;
   int          stall_left = 0;
   bit          in_word = 1'b0;
   always begin
      @(negedge clk);
      if (mul_in_valid && !reset) begin
         if (!in_word) begin
            in_word    = 1'b1;
            stall_left = stall_cfg;
            pa         = mul_a;
            pb         = mul_b;
         end else begin
            check("mul_a_stable", mul_a, pa);
            check("mul_b_stable", mul_b, pb);
         end
         if (stall_left > 0) begin
            mul_in_ready = 1'b0;
            stall_left--;
         end else begin
            mul_in_ready = 1'b1;
            check("mul_sew", {30'h0, mul_sew}, {30'h0, cur_sew});
            @(posedge clk);
            #1;
            mul_in_ready = 1'b0;
            in_word      = 1'b0;
            repeat (mul_lat - 1) begin
               @(posedge clk);
               #1;
            end
            mul_res       = pa + pb;
            mul_res_valid = 1'b1;
            @(posedge clk);
            #1;
            mul_res_valid = 1'b0;
            mul_res       = '0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_err", {31'h0, err}, 32'h0);
      check("rst_wr_en", {31'h0, rf_wr_en}, 32'h0);
      check("rst_mul_valid", {31'h0, mul_in_valid}, 32'h0);
      check("rst_mul_a", mul_a, 32'h0);
      check("rst_mul_sew", {30'h0, mul_sew}, 32'h0);
      reset = 1'b0;

      // SEW8, 6 elements: 6 bytes -> full word then 2-byte tail
      push_wr(8'h30, 8'h10, 8'h20, 4'hF);
      push_wr(8'h31, 8'h11, 8'h21, 4'h3);
      push_done(1'b0);
      issue(2'b00, 7'd6, 8'h10, 8'h20, 8'h30);
      wait_done("sew8_vl6");

      // SEW32, 3 elements with multiplier back-pressure
      stall_cfg = 5;
      for (int i = 0; i < 3; i++)
         push_wr(8'h40 + 8'(i), 8'h50 + 8'(i), 8'h60 + 8'(i), 4'hF);
      push_done(1'b0);
      issue(2'b10, 7'd3, 8'h50, 8'h60, 8'h40);
      wait_done("sew32_stall");
      stall_cfg = 0;

      // illegal SEW: done on the cycle right after acceptance, no traffic
      push_done(1'b1);
      issue(2'b11, 7'd5, 8'h01, 8'h02, 8'h03);
      @(negedge clk);
      check("illegal_done_next", {31'h0, done}, 32'h1);
      check("illegal_err", {31'h0, err}, 32'h1);
      check("illegal_ready_low", {31'h0, cmd_ready}, 32'h0);
      @(negedge clk);
      check("illegal_ready_back", {31'h0, cmd_ready}, 32'h1);
      check("illegal_busy_low", {31'h0, busy}, 32'h0);
      wait_done("illegal_sew");

      // vl = 0
      push_done(1'b0);
      issue(2'b01, 7'd0, 8'h01, 8'h02, 8'h03);
      wait_done("vl0");

      // destination and source address wrap
      push_wr(8'hFF, 8'hFE, 8'hFF, 4'hF);
      push_wr(8'h00, 8'hFF, 8'h00, 4'hF);
      push_done(1'b0);
      issue(2'b01, 7'd4, 8'hFE, 8'hFF, 8'hFF);
      wait_done("wrap");

      // vl 100 clamps to 64 SEW8 elements = 16 words, slower multiplier
      mul_lat = 3;
      for (int i = 0; i < 16; i++)
         push_wr(8'hA0 + 8'(i), 8'h80 + 8'(i), 8'h90 + 8'(i), 4'hF);
      push_done(1'b0);
      issue(2'b00, 7'd100, 8'h80, 8'h90, 8'hA0);
      wait_done("clamp");
      mul_lat = 1;

      // tail shapes: 7 bytes and 6 bytes
      push_wr(8'h10, 8'h20, 8'h30, 4'hF);
      push_wr(8'h11, 8'h21, 8'h31, 4'h7);
      push_done(1'b0);
      issue(2'b00, 7'd7, 8'h20, 8'h30, 8'h10);
      wait_done("tail7");
      push_wr(8'h18, 8'h28, 8'h38, 4'hF);
      push_wr(8'h19, 8'h29, 8'h39, 4'h3);
      push_done(1'b0);
      issue(2'b01, 7'd3, 8'h28, 8'h38, 8'h18);
      wait_done("tail6");

      // reset while waiting for the product; the late result must not be written
      mul_lat = 8;
      issue(2'b10, 7'd2, 8'h70, 8'h71, 8'h72);
      begin
         int t = 0;
         while (!mul_in_valid && t < 50) begin
            @(negedge clk);
            t++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort_busy", {31'h0, busy}, 32'h0);
      check("abort_cmd_ready", {31'h0, cmd_ready}, 32'h1);
      check("abort_wr_en", {31'h0, rf_wr_en}, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (14) @(negedge clk);
      mul_lat = 1;

`ifdef VMUL_MASK_EN
      next_vmask = '0;
      next_vmask[3:0] = 4'b0101;
      push_wr(8'h50, 8'h51, 8'h52, 4'b0101);
      push_done(1'b0);
      issue(2'b00, 7'd4, 8'h51, 8'h52, 8'h50);
      wait_done("mask_0101");
      next_vmask = '0;
      push_done(1'b0);
      issue(2'b00, 7'd4, 8'h51, 8'h52, 8'h50);
      wait_done("mask_zero");
      next_vmask = '1;
`endif

      repeat (3) @(negedge clk);
      check("writes_outstanding", exp_wr.size(), 32'h0);
      check("dones_outstanding", exp_done.size(), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
